// File: rtl/mem_ctl_pkg.sv
// Shared types and default widths for the burst memory controller.
// The state encoding is private to the controller; only its names are shared.
package mem_ctl_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int LEN_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [3:0] {
        IDLE,
        W_REQ,
        W_REL,
        W_ACK,
        C_ACK,
        R_REQ,
        R_REL,
        R_OUT,
        R_OREL,
        ERR
    } state_e;

    // States in which the controller is waiting on an external party.
    function automatic logic is_wait_state(input state_e s);
        return (s != IDLE) && (s != ERR);
    endfunction

endpackage

// File: rtl/mem_ctl_wdog.sv
// Watchdog: counts cycles spent in one state and flags expiry on the
// TIMEOUT-th cycle. TIMEOUT=0 disables it entirely.
module mem_ctl_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart || !enable) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q == LIMIT means this is the TIMEOUT-th cycle in the current state.
    assign expire = (TIMEOUT > 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/mem_ctl_burst.sv
// Four-phase command port to four-phase memory port bridge with single-word
// writes, auto-incrementing read bursts, a watchdog and a sticky error state.
module mem_ctl_burst
    import mem_ctl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic              wen,
    input  logic [ADDR_W-1:0] din_addr,
    input  logic [DATA_W-1:0] din_data,
    input  logic [LEN_W-1:0]  din_len,
    output logic              din_ack,
    output logic              dout_valid,
    input  logic              dout_ack,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] dout_data_q, dout_data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              din_ack_q, din_ack_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q, dout_last_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              wd_expire;

    mem_ctl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_d != state_q),
        .enable  (is_wait_state(state_q)),
        .expire  (wd_expire)
    );

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        beat_d      = beat_q;
        dout_data_d = dout_data_q;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    addr_d  = din_addr;
                    wdata_d = din_data;
                    len_d   = din_len;
                    beat_d  = '0;
                    state_d = wen ? W_REQ : C_ACK;
                end
            end
            W_REQ:  if (mem_done)   state_d = W_REL;
            W_REL:  if (!mem_done)  state_d = W_ACK;
            W_ACK:  if (!din_valid) state_d = IDLE;
            C_ACK:  if (!din_valid) state_d = R_REQ;
            R_REQ: begin
                if (mem_done) begin
                    dout_data_d = mem_rdata;
                    state_d     = R_REL;
                end
            end
            R_REL:  if (!mem_done)  state_d = R_OUT;
            R_OUT:  if (dout_ack)   state_d = R_OREL;
            R_OREL: begin
                if (!dout_ack) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = R_REQ;
                    end
                end
            end
            ERR: begin
                if (err_clr && !mem_done && !din_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A stalled handshake always loses to the watchdog.
        if (wd_expire) state_d = ERR;

        din_ack_d    = (state_d == W_ACK) || (state_d == C_ACK);
        mem_write_d  = (state_d == W_REQ);
        mem_read_d   = (state_d == R_REQ);
        dout_valid_d = (state_d == R_OUT);
        dout_last_d  = (state_d == R_OUT) && (beat_d == len_d);
        busy_d       = (state_d != IDLE);
        err_d        = (state_d == ERR);
    end

    // NOTE: state and outputs update with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            dout_data_q  <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            din_ack_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dout_data_q  <= dout_data_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            din_ack_q    <= din_ack_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign din_ack    = din_ack_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign dout_data  = dout_data_q;
    assign mem_write  = mem_write_q;
    assign mem_read   = mem_read_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_ctl_burst.sv
// Scoreboard bench for mem_ctl_burst: a driver issues random commands and
// queues expected memory accesses and read beats; a monitor pops and compares.
module tb_mem_ctl_burst;

    localparam int BUDGET = 400;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_exp_t;

    logic        clk, rst_n;
    logic        din_valid, wen, din_ack, dout_valid, dout_ack, dout_last;
    logic [7:0]  din_addr, mem_addr;
    logic [15:0] din_data, dout_data, mem_wdata, mem_rdata;
    logic [3:0]  din_len;
    logic        mem_write, mem_read, mem_done, busy, err, err_clr;

    logic        t_din_valid, t_din_ack, t_dout_valid, t_dout_last;
    logic        t_mem_write, t_mem_read, t_busy, t_err, t_err_clr;
    logic [7:0]  t_mem_addr;
    logic [15:0] t_dout_data, t_mem_wdata;

    logic [15:0] sram      [256];
    logic [15:0] model_mem [256];
    mem_exp_t    exp_mem[$];
    beat_exp_t   exp_beat[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_ctl_burst #(.ADDR_W(8), .DATA_W(16), .LEN_W(4), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .wen(wen),
        .din_addr(din_addr), .din_data(din_data), .din_len(din_len),
        .din_ack(din_ack), .dout_valid(dout_valid), .dout_ack(dout_ack),
        .dout_data(dout_data), .dout_last(dout_last), .mem_write(mem_write),
        .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy), .err(err),
        .err_clr(err_clr)
    );

    mem_ctl_burst #(.ADDR_W(8), .DATA_W(16), .LEN_W(4), .TIMEOUT(16)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .din_valid(t_din_valid), .wen(1'b0),
        .din_addr(8'h40), .din_data(16'h0000), .din_len(4'h0),
        .din_ack(t_din_ack), .dout_valid(t_dout_valid), .dout_ack(1'b0),
        .dout_data(t_dout_data), .dout_last(t_dout_last), .mem_write(t_mem_write),
        .mem_read(t_mem_read), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_rdata(16'h0000), .mem_done(1'b0), .busy(t_busy), .err(t_err),
        .err_clr(t_err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return din_ack;
            1:       return dout_valid;
            default: return busy;
        endcase
    endfunction

    task automatic wait_until(input int w, input logic lvl, input string name);
        int n = 0;
        while (sel(w) !== lvl && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(name, sel(w), lvl);
    endtask

    // Memory: four-phase responder with random latency, backed by sram[].
    initial begin
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_write || mem_read) && !mem_done) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (mem_write) sram[mem_addr] = mem_wdata;
                else           mem_rdata = sram[mem_addr];
                mem_done = 1'b1;
                for (int k = 0; k < BUDGET && (mem_write || mem_read); k++) @(negedge clk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                mem_done  = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: compares memory requests and read beats against the queues.
    initial begin
        logic        prev_req, prev_dv, req;
        logic [15:0] held_data;
        logic        held_last;
        mem_exp_t    me;
        beat_exp_t   be;
        prev_req = 1'b0;
        prev_dv  = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_req = 1'b0;
                prev_dv  = 1'b0;
                continue;
            end
            req = mem_write || mem_read;
            if (busy) begin
                check("mem_exclusive", mem_write && mem_read, 1'b0);
                if (!dout_valid) check("last_without_valid", dout_last, 1'b0);
                if (dout_valid)  check("no_mem_during_out", req, 1'b0);
            end
            if (req && !prev_req) begin
                check("req_while_done", mem_done, 1'b0);
                if (exp_mem.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_unexpected: access addr %0h with none expected", mem_addr);
                end else begin
                    me = exp_mem.pop_front();
                    check("mem_kind", mem_write, me.wr);
                    check("mem_addr", mem_addr, me.addr);
                    if (me.wr) check("mem_wdata", mem_wdata, me.wdata);
                end
            end
            if (dout_valid && !prev_dv) begin
                if (exp_beat.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: data %0h with none expected", dout_data);
                end else begin
                    be = exp_beat.pop_front();
                    check("beat_data", dout_data, be.data);
                    check("beat_last", dout_last, be.last);
                end
                held_data = dout_data;
                held_last = dout_last;
            end else if (dout_valid && prev_dv) begin
                check("beat_data_stable", dout_data, held_data);
                check("beat_last_stable", dout_last, held_last);
            end
            prev_req = req;
            prev_dv  = dout_valid;
        end
    end

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        mem_exp_t me;
        me.wr = 1'b1; me.addr = a; me.wdata = d;
        exp_mem.push_back(me);
        model_mem[a] = d;
        @(negedge clk);
        wen = 1'b1; din_addr = a; din_data = d; din_len = 4'($urandom);
        din_valid = 1'b1;
        @(negedge clk);
        check("wr_latency", mem_write, 1'b1);
        wait_until(0, 1'b1, "wr_ack");
        check("wr_done_before_ack", sram[a], d);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        din_valid = 1'b0;
        din_addr = 8'($urandom);
        wait_until(2, 1'b0, "wr_idle");
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len, input int bp, input int abort_beat);
        mem_exp_t  me;
        beat_exp_t be;
        for (int i = 0; i <= int'(len); i++) begin
            me.wr = 1'b0; me.addr = 8'((int'(a) + i) % 256); me.wdata = '0;
            exp_mem.push_back(me);
            be.data = model_mem[(int'(a) + i) % 256];
            be.last = (i == int'(len));
            exp_beat.push_back(be);
        end
        @(negedge clk);
        wen = 1'b0; din_addr = a; din_len = len; din_data = 16'($urandom);
        din_valid = 1'b1;
        wait_until(0, 1'b1, "rd_cmd_ack");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        din_valid = 1'b0;
        din_addr = 8'($urandom);
        din_len  = 4'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            wait_until(1, 1'b1, "rd_beat_valid");
            if (i == abort_beat) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("reset_outputs_zero",
                      {din_ack, dout_valid, dout_last, dout_data, mem_write, mem_read,
                       mem_addr, mem_wdata, busy, err}, 64'd0);
                exp_mem.delete();
                exp_beat.delete();
                dout_ack = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            repeat ((i == 0) ? bp : int'($urandom_range(0, 3))) @(negedge clk);
            dout_ack = 1'b1;
            wait_until(1, 1'b0, "rd_beat_release");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            dout_ack = 1'b0;
        end
        wait_until(2, 1'b0, "rd_idle");
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) begin
            sram[i]      = 16'($urandom);
            model_mem[i] = sram[i];
        end
        rst_n = 1'b0;
        din_valid = 1'b0; wen = 1'b0; din_addr = '0; din_data = '0; din_len = '0;
        dout_ack = 1'b0; err_clr = 1'b0;
        t_din_valid = 1'b0; t_err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",
              {din_ack, dout_valid, dout_last, dout_data, mem_write, mem_read,
               mem_addr, mem_wdata, busy, err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Watchdog: memory never answers the read request.
        t_din_valid = 1'b1;
        n = 0;
        while (!t_din_ack && n < 50) begin @(negedge clk); n++; end
        check("to_cmd_ack", t_din_ack, 1'b1);
        t_din_valid = 1'b0;
        n = 0;
        while (!t_mem_read && n < 50) begin @(negedge clk); n++; end
        check("to_mem_read", t_mem_read, 1'b1);
        n = 0;
        while (!t_err && n < 100) begin @(negedge clk); n++; end
        check("to_cycles", n, 16);
        check("to_err", t_err, 1'b1);
        check("to_mem_read_off", t_mem_read, 1'b0);
        check("to_busy", t_busy, 1'b1);
        repeat (5) @(negedge clk);
        check("to_err_sticky", t_err, 1'b1);
        t_err_clr = 1'b1;
        @(negedge clk);
        t_err_clr = 1'b0;
        check("to_err_cleared", {t_err, t_busy}, 2'b00);

        do_write(8'h12, 16'hBEEF);

        sram[8'hFE] = 16'h00A0; sram[8'hFF] = 16'h00A1;
        sram[8'h00] = 16'h00A2; sram[8'h01] = 16'h00A3;
        model_mem[8'hFE] = 16'h00A0; model_mem[8'hFF] = 16'h00A1;
        model_mem[8'h00] = 16'h00A2; model_mem[8'h01] = 16'h00A3;
        do_read(8'hFE, 4'd3, 0, -1);

        do_read(8'($urandom), 4'd1, 50, -1);
        do_read(8'h12, 4'd0, 0, -1);
        do_read(8'($urandom), 4'hF, 0, -1);

        do_read(8'($urandom), 4'd3, 0, 1);
        do_read(8'($urandom), 4'd0, 0, -1);

        for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 1) == 1) do_write(8'($urandom), 16'($urandom));
            else do_read(8'($urandom), 4'($urandom), 0, -1);
        end

        repeat (10) @(negedge clk);
        check("mem_queue_empty", exp_mem.size(), 0);
        check("beat_queue_empty", exp_beat.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctl_burst.md
Name: mem_ctl_burst

Overview:
Synchronous, parametrised successor to the team's four-phase memory controller. Accepts a command on a din four-phase handshake and drives a four-phase mem_write/mem_read/mem_done handshake to the memory. Single-word writes; read bursts of 1..MAX_BURST words, each returned on a dout four-phase handshake. Adds address/data paths, auto-increment, a watchdog timeout and a sticky error state; sits between the host-side request port and the SRAM wrapper.

Parameters:
ADDR_W, 8, address width
DATA_W, 16, data width
LEN_W, 4, burst-length field width; MAX_BURST = 2**LEN_W
TIMEOUT, 1024, max cycles in any wait state before error; 0 disables watchdog

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
din_valid  in  1  command request, four-phase
wen  in  1  1 = write, 0 = read; sampled with din_valid in IDLE
din_addr  in  ADDR_W  start address
din_data  in  DATA_W  write data
din_len  in  LEN_W  read beats minus 1; ignored for writes
din_ack  out  1  command acknowledge
dout_valid  out  1  read data valid, four-phase
dout_ack  in  1  read data acknowledge
dout_data  out  DATA_W  read data, stable while dout_valid=1
dout_last  out  1  high with dout_valid on the final beat
mem_write  out  1  memory write request
mem_read  out  1  memory read request
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_done=1
mem_done  in  1  memory completion, four-phase
busy  out  1  state != IDLE
err  out  1  sticky timeout flag
err_clr  in  1  clears err and leaves ERR

Behaviour:
- All inputs synchronous to clk; no internal synchronisers. All outputs registered; handshake outputs are Moore functions of state.
- Reset (asynchronous, immediate): state=IDLE; every output 0; internal address, length, beat counters and timer cleared. Reset mid-burst abandons the burst, with no completion beat.
- IDLE: on din_valid=1, latch din_addr, din_data, din_len, wen; beat=0; go to W_REQ if wen=1, else to C_ACK.
- W_REQ: mem_write=1, mem_addr and mem_wdata driven. On mem_done=1, go to W_REL.
- W_REL: mem_write=0. On mem_done=0, go to W_ACK.
- W_ACK: din_ack=1. On din_valid=0, go to IDLE (din_ack falls).
- C_ACK: din_ack=1 (command accepted before data). On din_valid=0, go to R_REQ.
- R_REQ: mem_read=1. On mem_done=1, capture mem_rdata into dout_data, go to R_REL.
- R_REL: mem_read=0. On mem_done=0, go to R_OUT.
- R_OUT: dout_valid=1; dout_last=(beat==len). On dout_ack=1, go to R_OREL.
- R_OREL: dout_valid=0, dout_last=0. On dout_ack=0: if beat==len, go to IDLE; else beat+1, addr+1, go to R_REQ.
- Address increments modulo 2**ADDR_W (wraps from all-ones to 0). len=all-ones gives MAX_BURST beats.
- Minimum latency: din_valid sampled at edge N gives mem_write=1 after edge N. Each phase change costs at least one cycle.
- Watchdog: counter resets on every state change and counts cycles in every non-IDLE, non-ERR state. When count reaches TIMEOUT, go to ERR.
- ERR: all handshake outputs 0, err=1, busy=1. Exit to IDLE when err_clr=1 and mem_done=0 and din_valid=0; err clears on that exit. err_clr outside ERR has no effect.
- wen and din_* are ignored outside IDLE. A new command needs din_valid to return low first; this is inherent in the four-phase protocol.
- mem_write and mem_read are never high together; mem_* is never requested while mem_done=1.

Decomposition:
- Package mem_ctl_pkg: state enum (IDLE, W_REQ, W_REL, W_ACK, C_ACK, R_REQ, R_REL, R_OUT, R_OREL, ERR) and the default width constants.
- Sub-module mem_ctl_wdog: watchdog counter with restart/enable inputs and an expire output, width $clog2(TIMEOUT+1).
- FSM, address/beat counters and datapath registers live in mem_ctl_burst.

Test Plan:
- Write: addr=0x12, data=0xBEEF, wen=1 -> mem_write=1 with mem_addr=0x12, mem_wdata=0xBEEF; after mem_done rises and falls, din_ack=1; din_valid low -> IDLE.
- Read burst: addr=0xFE, len=3, memory returns 0xA0..0xA3 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01; dout_data 0xA0..0xA3; dout_last only on the fourth beat.
- Back-pressure: hold dout_ack=0 for 50 cycles -> dout_valid and dout_data stable; no mem_read issued meanwhile.
- Timeout: TIMEOUT=16, mem_done stuck low in R_REQ -> err=1 on cycle 16, mem_read=0; err_clr with din_valid=0 -> IDLE, err=0.
- Reset mid-burst: rst_n low during R_OUT of beat 2 -> all outputs 0 immediately; next read with len=0 runs exactly one beat.
- Max burst: len=4'hF -> exactly 16 dout beats; dout_last on beat 16 only.
